// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback unit.
// Holds one instruction from the memory stage, forms the register-file
// write (ALU result, aligned/extended load data or PC+4), flags misaligned
// or illegal loads, mirrors the write onto a forwarding tap for decode and
// counts retired instructions.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  input  logic [1:0]       in_sel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mem,
  input  logic [XLEN-1:0]  in_pc4,
  output logic [4:0]       w_reg,
  output logic [XLEN-1:0]  w_dat,
  output logic             write,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [XLEN-1:0]  fwd_dat,
  output logic             ld_err,
  output logic [CNT_W-1:0] instret
);

  // Writeback source select encodings.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  // Load type encodings (funct3).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Captured pipeline entry.
  logic             valid_reg;
  logic [4:0]       rd_reg;
  logic             wen_reg;
  logic [1:0]       sel_reg;
  logic [2:0]       funct3_reg;
  logic [XLEN-1:0]  alu_reg;
  logic [XLEN-1:0]  mem_reg;
  logic [XLEN-1:0]  pc4_reg;
  logic [CNT_W-1:0] instret_reg;

  // Next-state and control.
  logic             valid_next;
  logic             capture;
  logic             consume;
  logic [CNT_W-1:0] instret_next;

  // Load datapath.
  logic [1:0]       off;
  logic [7:0]       lane [4];
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_data;
  logic             err;
  logic             sel_ok;
  logic [XLEN-1:0]  wb_data;
  logic             write_en;

  // The stage can always accept unless frozen; a flush still "accepts"
  // the cycle, it just discards what is presented.
  assign in_ready = ~hold;

  // Handshake: capture a new entry and consume (retire) the held one.
  always_comb begin
    capture = in_valid & ~hold & ~flush;
    consume = valid_reg & ~hold & ~flush;
  end

  // Entry occupancy: flush kills, hold freezes, otherwise follow in_valid.
  always_comb begin
    valid_next = valid_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (!hold) begin
      valid_next = in_valid;
    end
  end

  // Retirement counter advances once per consumed entry, wrapping naturally.
  always_comb begin
    instret_next = instret_reg;
    if (consume) begin
      instret_next = instret_reg + CNT_W'(1);
    end
  end

  // Occupancy and retirement state; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      instret_reg <= '0;
    end else begin
      valid_reg   <= valid_next;
      instret_reg <= instret_next;
    end
  end

  // Captured fields; they are kept (not cleared) when nothing new arrives so
  // w_reg/w_dat stay stable between instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_reg     <= '0;
      wen_reg    <= 1'b0;
      sel_reg    <= '0;
      funct3_reg <= '0;
      alu_reg    <= '0;
      mem_reg    <= '0;
      pc4_reg    <= '0;
    end else if (capture) begin
      rd_reg     <= in_rd;
      wen_reg    <= in_wen;
      sel_reg    <= in_sel;
      funct3_reg <= in_funct3;
      alu_reg    <= in_alu;
      mem_reg    <= in_mem;
      pc4_reg    <= in_pc4;
    end
  end

  // Byte offset within the aligned word comes from the low address bits.
  assign off = alu_reg[1:0];

  // Split the raw memory word into its four byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = mem_reg[8*gi +: 8];
    end
  endgenerate

  // Pick the addressed byte and the addressed halfword (half chosen by off[1]).
  always_comb begin
    byte_sel = lane[off];
    half_sel = {lane[{off[1], 1'b1}], lane[{off[1], 1'b0}]};
  end

  // Extend the selected byte/half to full width according to the load type.
  always_comb begin
    load_data = '0;
    case (funct3_reg)
      F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   load_data = mem_reg;
      default: load_data = '0;
    endcase
  end

  // Load fault detection: reserved funct3 codes and misaligned half/word.
  always_comb begin
    err = 1'b0;
    if (sel_reg == SEL_LOAD) begin
      case (funct3_reg)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = off[0];
        F3_LW:         err = |off;
        default:       err = 1'b1;
      endcase
    end
  end

  // Writeback source mux; the reserved select yields zero and never writes.
  always_comb begin
    wb_data = '0;
    sel_ok  = 1'b1;
    case (sel_reg)
      SEL_ALU:  wb_data = alu_reg;
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = pc4_reg;
      default: begin
        wb_data = '0;
        sel_ok  = 1'b0;
      end
    endcase
  end

  // Register-file write enable: only a retiring, well-formed write to a
  // non-zero register; a faulting load retires but does not write.
  always_comb begin
    write_en = consume & wen_reg & (rd_reg != 5'd0) & sel_ok & ~err;
  end

  // Register-file port, forwarding tap and status outputs.
  always_comb begin
    w_reg     = rd_reg;
    w_dat     = wb_data;
    write     = write_en;
    fwd_valid = write_en;
    fwd_reg   = rd_reg;
    fwd_dat   = wb_data;
    ld_err    = consume & err;
    instret   = instret_reg;
  end

endmodule
